// File: rtl/zx_mem_mapper.sv
// ZX Spectrum 128k/+2A/+3 memory mapper.
// Decodes the 7FFD, 1FFD and FE port writes, applies the paging registers
// to the CPU address, and optionally auto-pages the TR-DOS ROM.
// Ports:
//   clock, reset          system clock, async active-high reset
//   a, d_in               CPU address bus and write data
//   n_m1 .. n_wr          CPU strobes (active low)
//   ram_addr, rom_addr    physical addresses {page, a[13:0]}
//   is_rom, mem_we        access targets ROM / RAM write enable
//   trdos_active          TR-DOS ROM mapped at 0000-3FFF
//   screen_page           page scanned by video (5 or 7)
//   border, speaker, tape_out, paging_locked  ULA / paging status
module zx_mem_mapper #(
    parameter int unsigned RAM_BANK_BITS = 3,
    parameter int unsigned ENABLE_PLUS3  = 0,
    parameter int unsigned ENABLE_TRDOS  = 0,
    parameter int unsigned FULL_DECODE   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [15:0]               a,
    input  logic [7:0]                d_in,
    input  logic                      n_m1,
    input  logic                      n_mreq,
    input  logic                      n_iorq,
    input  logic                      n_rd,
    input  logic                      n_wr,
    output logic [RAM_BANK_BITS+13:0] ram_addr,
    output logic [15:0]               rom_addr,
    output logic                      is_rom,
    output logic                      trdos_active,
    output logic                      mem_we,
    output logic [RAM_BANK_BITS-1:0]  screen_page,
    output logic [2:0]                border,
    output logic                      speaker,
    output logic                      tape_out,
    output logic                      paging_locked
);

    localparam logic TRDOS_OFF = 1'b0;
    localparam logic TRDOS_ON  = 1'b1;

    logic [7:0]               reg_7ffd_q, reg_7ffd_d;
    logic [2:0]               reg_1ffd_q, reg_1ffd_d;
    logic [2:0]               border_q, border_d;
    logic                     speaker_q, speaker_d;
    logic                     tape_q, tape_d;
    logic                     trdos_state_q, trdos_state_d;
    logic [1:0]               io_sync_q, m1_sync_q;
    logic                     io_prev_q, m1_prev_q;
    logic                     wr_pulse, fetch_pulse;
    logic                     sel_7ffd, sel_1ffd, sel_fe;
    logic                     special_c;
    logic [1:0]               ext_c, rom_page_base_c, rom_page_c;
    logic [2:0]               sp_page_c;
    logic [RAM_BANK_BITS-1:0] page_c;
    logic                     unused_bits;

    assign unused_bits = ^{n_rd, reg_7ffd_q[7:6]};

    // Strobes come from the CPU clock domain: synchronise, then edge-detect.
    // Flops reset to "active" so a strobe held through reset cannot fire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_sync_q <= 2'b11;
            io_prev_q <= 1'b1;
            m1_sync_q <= 2'b11;
            m1_prev_q <= 1'b1;
        end else begin
            io_sync_q <= {io_sync_q[0], ~n_iorq & ~n_wr};
            io_prev_q <= io_sync_q[1];
            m1_sync_q <= {m1_sync_q[0], ~n_m1 & ~n_mreq};
            m1_prev_q <= m1_sync_q[1];
        end
    end

    assign wr_pulse    = io_sync_q[1] & ~io_prev_q;
    assign fetch_pulse = m1_sync_q[1] & ~m1_prev_q;

    // Port address decode.
    always_comb begin
        if (FULL_DECODE != 0) begin
            sel_7ffd = (a == 16'h7FFD);
            sel_1ffd = (a == 16'h1FFD);
            sel_fe   = (a == 16'h00FE);
        end else begin
            sel_7ffd = ~a[15] & ~a[1];
            sel_1ffd = (a[15:12] == 4'b0001) & ~a[1];
            sel_fe   = ~a[0];
        end
    end

    // Port register next state; overlapping partial decodes update every hit.
    always_comb begin
        reg_7ffd_d = reg_7ffd_q;
        reg_1ffd_d = reg_1ffd_q;
        border_d   = border_q;
        speaker_d  = speaker_q;
        tape_d     = tape_q;
        if (wr_pulse) begin
            if (sel_7ffd && !reg_7ffd_q[5]) begin
                reg_7ffd_d = d_in;
            end
            if (sel_1ffd && (ENABLE_PLUS3 != 0) && !reg_7ffd_q[5]) begin
                reg_1ffd_d = d_in[2:0];
            end
            if (sel_fe) begin
                border_d  = d_in[2:0];
                tape_d    = d_in[3];
                speaker_d = d_in[4] ^ d_in[3];
            end
        end
    end

    // TR-DOS auto-paging next state, evaluated once per opcode fetch.
    always_comb begin
        trdos_state_d = trdos_state_q;
        case (trdos_state_q)
            TRDOS_OFF: begin
                if (fetch_pulse && (ENABLE_TRDOS != 0) && (a[15:8] == 8'h3D)
                    && (rom_page_base_c == 2'b01)) begin
                    trdos_state_d = TRDOS_ON;
                end
            end
            TRDOS_ON: begin
                if (fetch_pulse && (a[15:14] != 2'b00)) begin
                    trdos_state_d = TRDOS_OFF;
                end
            end
            default: trdos_state_d = TRDOS_OFF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_7ffd_q    <= 8'h00;
            reg_1ffd_q    <= 3'b000;
            border_q      <= 3'b000;
            speaker_q     <= 1'b0;
            tape_q        <= 1'b0;
            trdos_state_q <= TRDOS_OFF;
        end else begin
            reg_7ffd_q    <= reg_7ffd_d;
            reg_1ffd_q    <= reg_1ffd_d;
            border_q      <= border_d;
            speaker_q     <= speaker_d;
            tape_q        <= tape_d;
            trdos_state_q <= trdos_state_d;
        end
    end

    // Memory map: purely combinational from address and paging registers.
    always_comb begin
        special_c = (ENABLE_PLUS3 != 0) && reg_1ffd_q[0];
        if (RAM_BANK_BITS >= 5) begin
            ext_c = reg_7ffd_q[7:6];
        end else if (RAM_BANK_BITS == 4) begin
            ext_c = {1'b0, reg_7ffd_q[6]};
        end else begin
            ext_c = 2'b00;
        end
        case ({reg_1ffd_q[2:1], a[15:14]})
            4'b00_00: sp_page_c = 3'd0;
            4'b00_01: sp_page_c = 3'd1;
            4'b00_10: sp_page_c = 3'd2;
            4'b00_11: sp_page_c = 3'd3;
            4'b01_00: sp_page_c = 3'd4;
            4'b01_01: sp_page_c = 3'd5;
            4'b01_10: sp_page_c = 3'd6;
            4'b01_11: sp_page_c = 3'd7;
            4'b10_00: sp_page_c = 3'd4;
            4'b10_01: sp_page_c = 3'd5;
            4'b10_10: sp_page_c = 3'd6;
            4'b11_00: sp_page_c = 3'd4;
            4'b11_01: sp_page_c = 3'd7;
            4'b11_10: sp_page_c = 3'd6;
            default:  sp_page_c = 3'd3;
        endcase
        is_rom = 1'b0;
        page_c = '0;
        if (special_c) begin
            page_c = RAM_BANK_BITS'(sp_page_c);
        end else begin
            case (a[15:14])
                2'b00:   is_rom = 1'b1;
                2'b01:   page_c = RAM_BANK_BITS'(5);
                2'b10:   page_c = RAM_BANK_BITS'(2);
                default: page_c = RAM_BANK_BITS'({ext_c, reg_7ffd_q[2:0]});
            endcase
        end
        rom_page_base_c = {(ENABLE_PLUS3 != 0) ? reg_1ffd_q[2] : 1'b0, reg_7ffd_q[4]};
        rom_page_c      = trdos_active ? 2'b11 : rom_page_base_c;
    end

    assign trdos_active  = (ENABLE_TRDOS != 0) && (trdos_state_q == TRDOS_ON);
    assign ram_addr      = {page_c, a[13:0]};
    assign rom_addr      = {rom_page_c, a[13:0]};
    assign mem_we        = ~n_mreq & ~n_wr & ~is_rom;
    assign screen_page   = reg_7ffd_q[3] ? RAM_BANK_BITS'(7) : RAM_BANK_BITS'(5);
    assign border        = border_q;
    assign speaker       = speaker_q;
    assign tape_out      = tape_q;
    assign paging_locked = reg_7ffd_q[5];

endmodule

// File: tb/tb_zx_mem_mapper.sv
// Bench for zx_mem_mapper: three configurations share one CPU bus and are
// compared against a register-level behavioural model of the Spectrum paging.
module tb_zx_mem_mapper;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic        n_m1, n_mreq, n_iorq, n_rd, n_wr;

    always #5 clock = ~clock;

    // Instance 0: 512k +3 with TR-DOS, full decode.
    logic [18:0] ram0; logic [15:0] rom0; logic [4:0] scr0;
    logic isr0, tr0, we0, spk0, tap0, lck0; logic [2:0] bor0;
    // Instance 1: 256k, partial decode.
    logic [17:0] ram1; logic [15:0] rom1; logic [3:0] scr1;
    logic isr1, tr1, we1, spk1, tap1, lck1; logic [2:0] bor1;
    // Instance 2: default 128k.
    logic [16:0] ram2; logic [15:0] rom2; logic [2:0] scr2;
    logic isr2, tr2, we2, spk2, tap2, lck2; logic [2:0] bor2;

    zx_mem_mapper #(.RAM_BANK_BITS(5), .ENABLE_PLUS3(1), .ENABLE_TRDOS(1), .FULL_DECODE(1)) u0 (
        .clock(clock), .reset(reset), .a(a), .d_in(d_in), .n_m1(n_m1), .n_mreq(n_mreq),
        .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .ram_addr(ram0), .rom_addr(rom0),
        .is_rom(isr0), .trdos_active(tr0), .mem_we(we0), .screen_page(scr0),
        .border(bor0), .speaker(spk0), .tape_out(tap0), .paging_locked(lck0));

    zx_mem_mapper #(.RAM_BANK_BITS(4), .ENABLE_PLUS3(0), .ENABLE_TRDOS(0), .FULL_DECODE(0)) u1 (
        .clock(clock), .reset(reset), .a(a), .d_in(d_in), .n_m1(n_m1), .n_mreq(n_mreq),
        .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .ram_addr(ram1), .rom_addr(rom1),
        .is_rom(isr1), .trdos_active(tr1), .mem_we(we1), .screen_page(scr1),
        .border(bor1), .speaker(spk1), .tape_out(tap1), .paging_locked(lck1));

    zx_mem_mapper u2 (
        .clock(clock), .reset(reset), .a(a), .d_in(d_in), .n_m1(n_m1), .n_mreq(n_mreq),
        .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .ram_addr(ram2), .rom_addr(rom2),
        .is_rom(isr2), .trdos_active(tr2), .mem_we(we2), .screen_page(scr2),
        .border(bor2), .speaker(spk2), .tape_out(tap2), .paging_locked(lck2));

    // Configuration of each instance, as seen by the model.
    int rbb  [3] = '{5, 4, 3};
    int p3   [3] = '{1, 0, 0};
    int trd  [3] = '{1, 0, 0};
    int full [3] = '{1, 0, 1};
    int sp_tbl [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};

    // Model state.
    int m7 [3], m1 [3], mb [3], mt [3], ms [3], mtr [3];

    int checks = 0;
    int errors = 0;

    function automatic bit hit(int k, int ad, int port);
        case (port)
            0:       return (full[k] != 0) ? (ad == 'h7FFD) : ((((ad >> 15) & 1) == 0) && (((ad >> 1) & 1) == 0));
            1:       return (full[k] != 0) ? (ad == 'h1FFD) : (((ad >> 12) == 1) && (((ad >> 1) & 1) == 0));
            default: return (full[k] != 0) ? (ad == 'h00FE) : ((ad & 1) == 0);
        endcase
    endfunction

    function automatic int model_page(int k, int ad);
        int slot = ad >> 14;
        if (p3[k] != 0 && (m1[k] & 1) != 0) return sp_tbl[(m1[k] >> 1) & 3][slot];
        case (slot)
            1:       return 5;
            2:       return 2;
            3:       return ((m7[k] & 7) + 8 * (m7[k] >> 6)) % (1 << rbb[k]);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m7[k] = 0; m1[k] = 0; mb[k] = 0; mt[k] = 0; ms[k] = 0; mtr[k] = 0;
        end
    endtask

    task automatic model_write(int ad, int d);
        for (int k = 0; k < 3; k++) begin
            int locked = (m7[k] >> 5) & 1;
            if (hit(k, ad, 1) && p3[k] != 0 && locked == 0) m1[k] = d;
            if (hit(k, ad, 2)) begin
                mb[k] = d & 7;
                mt[k] = (d >> 3) & 1;
                ms[k] = ((d >> 4) ^ (d >> 3)) & 1;
            end
            if (hit(k, ad, 0) && locked == 0) m7[k] = d;
        end
    endtask

    task automatic model_fetch(int ad);
        for (int k = 0; k < 3; k++) begin
            if (trd[k] != 0) begin
                int base = ((p3[k] != 0) ? ((m1[k] >> 2) & 1) : 0) * 2 + ((m7[k] >> 4) & 1);
                if (mtr[k] == 0 && (ad >> 8) == 'h3D && base == 1) mtr[k] = 1;
                else if (mtr[k] != 0 && (ad >> 14) != 0) mtr[k] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %0d.%s observed=%0h expected=%0h", k, tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present a memory address (optionally as a write) and compare all outputs.
    task automatic check_all(input logic [15:0] addr, input bit we);
        logic [31:0] o_ram, o_rom, o_isr, o_tr, o_we, o_scr, o_bor, o_spk, o_tap, o_lck;
        int ad = int'(addr);
        a = addr; n_mreq = ~we; n_wr = ~we;
        #1;
        for (int k = 0; k < 3; k++) begin
            int e_isr = ((p3[k] != 0 && (m1[k] & 1) != 0) || (ad >> 14) != 0) ? 0 : 1;
            int e_rp  = (mtr[k] != 0) ? 3 : ((p3[k] != 0) ? ((m1[k] >> 2) & 1) : 0) * 2 + ((m7[k] >> 4) & 1);
            case (k)
                0: begin o_ram = 32'(ram0); o_rom = 32'(rom0); o_isr = 32'(isr0); o_tr = 32'(tr0); o_we = 32'(we0);
                         o_scr = 32'(scr0); o_bor = 32'(bor0); o_spk = 32'(spk0); o_tap = 32'(tap0); o_lck = 32'(lck0); end
                1: begin o_ram = 32'(ram1); o_rom = 32'(rom1); o_isr = 32'(isr1); o_tr = 32'(tr1); o_we = 32'(we1);
                         o_scr = 32'(scr1); o_bor = 32'(bor1); o_spk = 32'(spk1); o_tap = 32'(tap1); o_lck = 32'(lck1); end
                default: begin o_ram = 32'(ram2); o_rom = 32'(rom2); o_isr = 32'(isr2); o_tr = 32'(tr2); o_we = 32'(we2);
                         o_scr = 32'(scr2); o_bor = 32'(bor2); o_spk = 32'(spk2); o_tap = 32'(tap2); o_lck = 32'(lck2); end
            endcase
            chk("is_rom", k, o_isr, 32'(e_isr));
            chk("rom_addr", k, o_rom, 32'(e_rp * 16384 + (ad % 16384)));
            if (e_isr == 0) chk("ram_addr", k, o_ram, 32'(model_page(k, ad) * 16384 + (ad % 16384)));
            chk("trdos", k, o_tr, 32'(mtr[k]));
            chk("mem_we", k, o_we, 32'((we && e_isr == 0) ? 1 : 0));
            chk("screen", k, o_scr, 32'(((m7[k] >> 3) & 1) != 0 ? 7 : 5));
            chk("border", k, o_bor, 32'(mb[k]));
            chk("speaker", k, o_spk, 32'(ms[k]));
            chk("tape", k, o_tap, 32'(mt[k]));
            chk("locked", k, o_lck, 32'((m7[k] >> 5) & 1));
        end
        n_mreq = 1'b1; n_wr = 1'b1;
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] d);
        a = addr; d_in = d; n_iorq = 1'b0; n_wr = 1'b0;
        tick(5);
        n_iorq = 1'b1; n_wr = 1'b1;
        tick(4);
        model_write(int'(addr), int'(d));
    endtask

    task automatic fetch(input logic [15:0] addr);
        a = addr; n_m1 = 1'b0; n_mreq = 1'b0; n_rd = 1'b0;
        tick(4);
        n_m1 = 1'b1; n_mreq = 1'b1; n_rd = 1'b1;
        tick(4);
        model_fetch(int'(addr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick(2);
        reset = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [15:0] ports [8];
        ports[0] = 16'h7FFD; ports[1] = 16'h1FFD; ports[2] = 16'h00FE; ports[3] = 16'h7FFC;
        ports[4] = 16'h3FFD; ports[5] = 16'h7FFF; ports[6] = 16'h1FFC; ports[7] = 16'hBFFD;

        reset = 1'b1; a = 16'h0000; d_in = 8'h00;
        n_m1 = 1'b1; n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
        model_reset();
        // Reset state visible before any clock edge.
        #2;
        check_all(16'h0000, 1'b0);
        check_all(16'hC000, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(4);
        check_all(16'h4123, 1'b0);

        // Extended bank bits and the lock.
        io_write(16'h7FFD, 8'hC3);
        check_all(16'hC000, 1'b0);
        io_write(16'h7FFD, 8'h20);
        check_all(16'hC000, 1'b0);
        io_write(16'h7FFD, 8'h07);
        check_all(16'hC123, 1'b0);
        io_write(16'h1FFD, 8'h01);
        check_all(16'h0000, 1'b0);

        // Special paging.
        do_reset();
        io_write(16'h1FFD, 8'h05);
        check_all(16'h0000, 1'b0);
        check_all(16'hC000, 1'b0);
        check_all(16'h0100, 1'b1);
        io_write(16'h1FFD, 8'h07);
        check_all(16'h4000, 1'b1);

        // TR-DOS auto-paging.
        do_reset();
        io_write(16'h7FFD, 8'h10);
        fetch(16'h3D2F);
        check_all(16'h0123, 1'b0);
        fetch(16'h4000);
        check_all(16'h0123, 1'b0);
        io_write(16'h7FFD, 8'h00);
        fetch(16'h3D00);
        check_all(16'h0000, 1'b0);

        // Held FE write: changing data mid-hold must not retrigger.
        a = 16'h00FE; d_in = 8'h1A; n_iorq = 1'b0; n_wr = 1'b0;
        tick(8);
        d_in = 8'h07;
        tick(32);
        n_iorq = 1'b1; n_wr = 1'b1;
        tick(4);
        model_write('h00FE, 'h1A);
        check_all(16'h8000, 1'b0);

        // Partial decode addresses.
        do_reset();
        io_write(16'h7FFF, 8'h07);
        check_all(16'hC000, 1'b0);
        io_write(16'h3FFD, 8'h06);
        check_all(16'hC000, 1'b0);
        io_write(16'h7FFC, 8'h11);
        check_all(16'hC000, 1'b0);

        // Reset in the middle of an I/O write; held strobe after release is ignored.
        a = 16'h7FFD; d_in = 8'h0B; n_iorq = 1'b0; n_wr = 1'b0;
        tick(2);
        reset = 1'b1;
        model_reset();
        #1;
        check_all(16'hC000, 1'b0);
        a = 16'h7FFD; n_wr = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(10);
        n_iorq = 1'b1; n_wr = 1'b1;
        check_all(16'hC000, 1'b0);
        tick(4);
        io_write(16'h7FFD, 8'h0B);
        check_all(16'hC000, 1'b0);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int op = int'($urandom_range(0, 15));
            if (op == 0) begin
                do_reset();
            end else if (op < 8) begin
                logic [15:0] pa;
                pa = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ports[$urandom_range(0, 7)];
                io_write(pa, 8'($urandom));
            end else if (op < 11) begin
                logic [15:0] fa;
                fa = ($urandom_range(0, 1) == 0) ? {8'h3D, 8'($urandom)} : 16'($urandom);
                fetch(fa);
            end
            check_all(16'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
